// File: rtl/add8_err_stats.sv
// add8_err_stats
// Streaming error-characterisation stage for an 8-bit approximate adder.
// Each accepted sample (a, b, o_approx) is compared against the exact sum
// a + b.  The block accumulates the error count, the absolute-error sum, the
// squared-error sum and the worst-case error over a run of cfg_len samples.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, cfg_len    run launch pulse and run length (sampled on start)
//   in_valid/in_ready sample handshake; in_ready never looks at in_valid
//   a, b, o_approx    operands and approximate adder result
//   busy, done        run in progress / results final and frozen
//   n_samp            samples accepted in the current or last run
//   err_cnt, abs_sum  count of erroneous samples, sum of |err|
//   sq_sum, wce       sum of err^2, largest |err| seen
module add8_err_stats #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [8:0]       o_approx,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] n_samp,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] abs_sum,
  output logic [ACC_W-1:0] sq_sum,
  output logic [8:0]       wce
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] n_samp_reg;

  // Stage 1: per-sample error
  logic             s1_valid_reg;
  logic [8:0]       s1_err_reg;
  logic             s1_nz_reg;

  // Stage 2: accumulators
  logic [ACC_W-1:0] err_cnt_reg;
  logic [ACC_W-1:0] abs_sum_reg;
  logic [ACC_W-1:0] sq_sum_reg;
  logic [8:0]       wce_reg;

  logic             accept;
  logic [8:0]       exact;
  logic [8:0]       err_calc;
  logic [17:0]      sq_term;
  logic [ACC_W:0]   abs_wide;
  logic [ACC_W:0]   sq_wide;
  logic [ACC_W-1:0] abs_next;
  logic [ACC_W-1:0] sq_next;
  logic [ACC_W-1:0] cnt_next;
  logic [8:0]       wce_next;

  // in_ready comes from registered state only. It falls on the same edge
  // that makes n_samp reach len_reg, so no sample beyond the run length
  // is ever accepted.
  assign in_ready = (state_reg == RUN) && (n_samp_reg < len_reg);
  assign accept   = in_valid && in_ready;

  // The exact sum needs all 9 bits (255 + 255 = 510).
  assign exact    = {1'b0, a} + {1'b0, b};
  assign err_calc = (exact >= o_approx) ? (exact - o_approx) : (o_approx - exact);

  // err <= 511, so err^2 fits in 18 bits.
  assign sq_term  = {9'd0, s1_err_reg} * {9'd0, s1_err_reg};

  // Each sum is formed one bit wider. The carry-out means the result
  // overflowed, and the accumulator then sticks at all-ones.
  assign abs_wide = {1'b0, abs_sum_reg} + (ACC_W+1)'(s1_err_reg);
  assign sq_wide  = {1'b0, sq_sum_reg} + (ACC_W+1)'(sq_term);
  assign abs_next = abs_wide[ACC_W] ? {ACC_W{1'b1}} : abs_wide[ACC_W-1:0];
  assign sq_next  = sq_wide[ACC_W] ? {ACC_W{1'b1}} : sq_wide[ACC_W-1:0];
  assign cnt_next = (s1_nz_reg && !(&err_cnt_reg)) ? err_cnt_reg + 1'b1 : err_cnt_reg;
  assign wce_next = (s1_err_reg > wce_reg) ? s1_err_reg : wce_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      n_samp_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= '0;
      s1_nz_reg    <= 1'b0;
      err_cnt_reg  <= '0;
      abs_sum_reg  <= '0;
      sq_sum_reg   <= '0;
      wce_reg      <= '0;
    end else begin
      // Stage 1 captures only accepted samples.
      s1_valid_reg <= accept;
      if (accept) begin
        s1_err_reg <= err_calc;
        s1_nz_reg  <= (err_calc != 9'd0);
      end

      // Stage 2 folds the stage-1 sample into the totals.
      if (s1_valid_reg) begin
        err_cnt_reg <= cnt_next;
        abs_sum_reg <= abs_next;
        sq_sum_reg  <= sq_next;
        wce_reg     <= wce_next;
      end

      case (state_reg)
        IDLE, DONE: begin
          // The pipeline is empty here, so clearing the totals cannot
          // lose a sample that is still in flight.
          if (start) begin
            state_reg    <= RUN;
            len_reg      <= cfg_len;
            n_samp_reg   <= '0;
            s1_valid_reg <= 1'b0;
            err_cnt_reg  <= '0;
            abs_sum_reg  <= '0;
            sq_sum_reg   <= '0;
            wce_reg      <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            n_samp_reg <= n_samp_reg + 1'b1;
          end
          // The registered count is compared, so a zero-length run
          // also passes through RUN for exactly one cycle.
          if (n_samp_reg == len_reg) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid_reg) begin
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
  assign done    = (state_reg == DONE);
  assign n_samp  = n_samp_reg;
  assign err_cnt = err_cnt_reg;
  assign abs_sum = abs_sum_reg;
  assign sq_sum  = sq_sum_reg;
  assign wce     = wce_reg;

endmodule

// File: tb/tb_add8_err_stats.sv
// Testbench for add8_err_stats, built with ACC_W=18 so that the saturation
// run can reach the accumulator limit.
// A scoreboard queue receives the expected |err| of every accepted sample,
// and those values are compared against the running totals two edges later.
// Table-driven runs check the final totals and the timing of done.
// Hand-written sequences cover reset, backpressure, zero length and restarts.
module tb_add8_err_stats;
  localparam int ACC_W = 18;
  localparam int LEN_W = 16;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       a = '0;
  logic [7:0]       b = '0;
  logic [8:0]       o_approx = '0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] n_samp;
  logic [ACC_W-1:0] err_cnt;
  logic [ACC_W-1:0] abs_sum;
  logic [ACC_W-1:0] sq_sum;
  logic [8:0]       wce;

  add8_err_stats #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .o_approx(o_approx), .busy(busy), .done(done), .n_samp(n_samp),
    .err_cnt(err_cnt), .abs_sum(abs_sum), .sq_sum(sq_sum), .wce(wce)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sa;
    logic [7:0] sb;
    logic [8:0] so;
  } samp_t;

  typedef struct {
    int     len;
    int     first;
    int     gap;
    longint e_cnt;
    longint e_abs;
    longint e_sq;
    longint e_wce;
  } run_t;

  samp_t samp_tbl[11];
  run_t  run_tbl[4];

  int     n_chk = 0;
  int     n_fail = 0;
  longint m_cnt, m_abs, m_sq, m_wce;
  int     m_n;
  int     exp_q[$];
  bit     d1, d2, model_clr, mon_on;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_err(input int aa, input int bb, input int oo);
    int e;
    e = aa + bb - oo;
    return (e < 0) ? -e : e;
  endfunction

  function automatic longint sat(input longint v);
    return (v > ACC_MAX) ? ACC_MAX : v;
  endfunction

  // Scoreboard monitor, called once per cycle at the falling edge.
  task automatic mon();
    int e;
    if (model_clr) begin
      m_cnt = 0; m_abs = 0; m_sq = 0; m_wce = 0; m_n = 0;
      exp_q.delete();
      d1 = 0; d2 = 0; model_clr = 0;
    end else if (mon_on) begin
      if (d2) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          m_cnt = sat(m_cnt + ((e != 0) ? 1 : 0));
          m_abs = sat(m_abs + e);
          m_sq  = sat(m_sq + longint'(e) * e);
          if (e > m_wce) m_wce = e;
          check("err_cnt_run", err_cnt, m_cnt);
          check("abs_sum_run", abs_sum, m_abs);
          check("sq_sum_run", sq_sum, m_sq);
          check("wce_run", wce, m_wce);
        end
      end
      if (d1) m_n++;
      check("n_samp_run", n_samp, m_n);
    end
    d2 = d1;
    d1 = in_valid && in_ready;
    if (d1) exp_q.push_back(ref_err(int'(a), int'(b), int'(o_approx)));
  endtask

  // Advances one cycle. Inputs change at rising edge + 1; the monitor runs at the falling edge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit honoured);
    cfg_len = LEN_W'(len);
    start = 1'b1;
    if (honoured) model_clr = 1'b1;
    mon_on = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] aa, input logic [7:0] bb, input logic [8:0] oo, input int gap);
    bit got;
    in_valid = 1'b0;
    repeat (gap) step();
    a = aa; b = bb; o_approx = oo;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = d1;
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  // Runs after the last accept edge: done must rise exactly two edges later.
  task automatic check_done_timing(input string tag);
    check({tag, "_done_k"}, done, 1'b0);
    step();
    check({tag, "_done_k1"}, done, 1'b0);
    check({tag, "_busy_k1"}, busy, 1'b1);
    step();
    check({tag, "_done_k2"}, done, 1'b1);
    check({tag, "_busy_k2"}, busy, 1'b0);
  endtask

  task automatic check_totals(input string tag, input int n, input longint c,
                              input longint ab, input longint sq, input longint w);
    check({tag, "_n_samp"}, n_samp, n);
    check({tag, "_err_cnt"}, err_cnt, c);
    check({tag, "_abs_sum"}, abs_sum, ab);
    check({tag, "_sq_sum"}, sq_sum, sq);
    check({tag, "_wce"}, wce, w);
  endtask

  initial begin
    int acc_seen;
    samp_tbl = '{
      '{8'd3,   8'd5,   9'd8},   '{8'd255, 8'd255, 9'd510}, '{8'd0,  8'd0,  9'd0},
      '{8'd3,   8'd5,   9'd13},  '{8'd100, 8'd27,  9'd120}, '{8'd10, 8'd10, 9'd20},
      '{8'd255, 8'd255, 9'd0},   '{8'd255, 8'd255, 9'd0},   '{8'd255, 8'd255, 9'd0},
      '{8'd255, 8'd255, 9'd0},   '{8'd255, 8'd255, 9'd0}
    };
    run_tbl = '{
      '{3, 0, 0, 0, 0,    0,      0},
      '{3, 3, 2, 2, 12,   74,     7},
      '{3, 3, 0, 2, 12,   74,     7},
      '{5, 6, 0, 5, 2550, 262143, 510}
    };
    m_cnt = 0; m_abs = 0; m_sq = 0; m_wce = 0; m_n = 0;
    d1 = 0; d2 = 0; model_clr = 0; mon_on = 0;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_totals("rst", 0, 0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset mid-run discards everything
    do_start(4, 1'b1);
    feed(8'd3, 8'd5, 9'd13, 0);
    feed(8'd100, 8'd27, 9'd120, 0);
    step();
    rst_n = 1'b0;
    model_clr = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check_totals("midrst", 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // Table-driven runs: exact, mixed with gaps, mixed back-to-back
    // (restarted from DONE), saturation
    foreach (run_tbl[r]) begin
      do_start(run_tbl[r].len, 1'b1);
      check($sformatf("run%0d_cleared_cnt", r), err_cnt, 0);
      check($sformatf("run%0d_cleared_wce", r), wce, 0);
      check($sformatf("run%0d_cleared_n", r), n_samp, 0);
      for (int i = 0; i < run_tbl[r].len; i++) begin
        feed(samp_tbl[run_tbl[r].first + i].sa, samp_tbl[run_tbl[r].first + i].sb,
             samp_tbl[run_tbl[r].first + i].so, run_tbl[r].gap);
      end
      check_done_timing($sformatf("run%0d", r));
      check_totals($sformatf("run%0d", r), run_tbl[r].len, run_tbl[r].e_cnt,
                   run_tbl[r].e_abs, run_tbl[r].e_sq, run_tbl[r].e_wce);
    end

    // start during RUN is ignored
    do_start(2, 1'b1);
    feed(8'd3, 8'd5, 9'd13, 0);
    do_start(9, 1'b0);
    check("ign_busy", busy, 1'b1);
    feed(8'd100, 8'd27, 9'd120, 1);
    check_done_timing("ign");
    check_totals("ign", 2, 2, 12, 74, 7);

    // Backpressure: in_valid held high, only len samples are taken
    do_start(2, 1'b1);
    a = 8'd1; b = 8'd1; o_approx = 9'd3;
    in_valid = 1'b1;
    acc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d1) acc_seen++;
    end
    check("bp_accepts", acc_seen, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_n_samp", n_samp, 2);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !done; i++) step();
    check("bp_done", done, 1'b1);
    check_totals("bp", 2, 2, 2, 2, 1);

    // Zero-length run
    do_start(0, 1'b1);
    check("len0_busy_e1", busy, 1'b1);
    check("len0_in_ready", in_ready, 1'b0);
    step();
    check("len0_done_e2", done, 1'b0);
    check("len0_busy_e2", busy, 1'b1);
    step();
    check("len0_done_e3", done, 1'b1);
    check_totals("len0", 0, 0, 0, 0, 0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net against a hang
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
